gray_rgb565: RTL and testbench

GRAY_RGB565 -- requirements
Module: gray_rgb565

---
 rtl/gray_rgb565.sv | 255 +++++++++++++++++++++++++
 tb/tb_gray_rgb565.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rgb565.sv
// ---------------------------------------------------------------------------
// gray_rgb565 -- 8-bit grayscale stream to RGB565 stream with frame checking.
//
// Accepts one pixel per clock (no backpressure). A two-state framer filters
// the incoming sop/eop framing: pixels outside a frame are dropped, a sop
// inside a running frame restarts it (sop_err), and at every eop the frame
// length is compared with FRAME_PIX (len_err). Pipeline latency is 2 clk:
// stage 1 holds the gray value and filtered framing, stage 2 the colour
// mapped pixel. All output flags are aligned with the same output beat.
//
// Build option:
//   PSEUDO_COLOR_EN  defined   -> 4-segment heat-map colouring
//                    undefined -> grayscale replication {g[7:3],g[7:2],g[7:3]}
//
// Parameters:
//   FRAME_PIX  expected pixels per frame
//   CNT_W      pixel counter width (2**CNT_W > FRAME_PIX)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   din[7:0]     gray pixel
//   din_vld      pixel valid; qualifies din_sop / din_eop
//   din_sop      first pixel of a frame
//   din_eop      last pixel of a frame
//   dout[15:0]   RGB565 pixel {R[4:0],G[5:0],B[4:0]}, held while !dout_vld
//   dout_vld     output pixel valid
//   dout_sop     filtered frame start
//   dout_eop     filtered frame end
//   sop_err      pulse: frame restarted before its eop
//   len_err      pulse with dout_eop: frame length differs from FRAME_PIX
//   frame_done   pulse with dout_eop: frame completed
// ---------------------------------------------------------------------------
module gray_rgb565 #(
   parameter int FRAME_PIX = 307200,
   parameter int CNT_W     = 19
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_vld,
   input  logic        din_sop,
   input  logic        din_eop,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic        sop_err,
   output logic        len_err,
   output logic        frame_done
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [CNT_W:0]   FRAME_CHK   = (CNT_W+1)'(FRAME_PIX);
   localparam logic             ONE_PIX_ERR = (FRAME_PIX != 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

   // Colour mapping from an 8-bit gray level to RGB565.
   function automatic logic [15:0] map_pix(input logic [7:0] g);
`ifdef PSEUDO_COLOR_EN
      logic [7:0] k4;
      logic [7:0] r;
      logic [7:0] gr;
      logic [7:0] b;
      // 4*k where k is the offset inside the 64-wide segment; 255-x == ~x.
      k4 = {g[5:0], 2'b00};
      case (g[7:6])
         2'b00:   begin r = 8'h00; gr = k4;    b = 8'hFF; end
         2'b01:   begin r = 8'h00; gr = 8'hFF; b = ~k4;   end
         2'b10:   begin r = k4;    gr = 8'hFF; b = 8'h00; end
         default: begin r = 8'hFF; gr = ~k4;   b = 8'h00; end
      endcase
      return {r[7:3], gr[7:2], b[7:3]};
`else
      return {g[7:3], g[7:2], g[7:3]};
`endif
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] pix_cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W:0]   chk_s;

   logic             acc_s;
   logic             sop_s;
   logic             eop_s;
   logic             serr_s;
   logic             lerr_s;
   logic             fdone_s;

   logic [7:0]       s1_gray_r;
   logic             s1_vld_r;
   logic             s1_sop_r;
   logic             s1_eop_r;
   logic             s1_serr_r;
   logic             s1_lerr_r;
   logic             s1_fdone_r;

   // Frame length including the pixel currently presented (the eop pixel).
   assign chk_s = {1'b0, pix_cnt_r} + {{CNT_W{1'b0}}, 1'b1};

   // Framer state register and pixel counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         pix_cnt_r <= CNT_ZERO;
      end else begin
         state_r   <= state_nxt_s;
         pix_cnt_r <= cnt_nxt_s;
      end
   end

   // Framer next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (din_vld && din_sop && !din_eop) begin
               state_nxt_s = ACTIVE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACTIVE: begin
            if (din_vld && din_eop) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ACTIVE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Framer outputs: accept decision, filtered framing, error flags, counter.
   always_comb begin
      acc_s     = 1'b0;
      sop_s     = 1'b0;
      eop_s     = 1'b0;
      serr_s    = 1'b0;
      lerr_s    = 1'b0;
      fdone_s   = 1'b0;
      cnt_nxt_s = pix_cnt_r;
      case (state_r)
         IDLE: begin
            if (din_vld && din_sop) begin
               acc_s     = 1'b1;
               sop_s     = 1'b1;
               cnt_nxt_s = CNT_ONE;
               if (din_eop) begin
                  eop_s   = 1'b1;
                  fdone_s = 1'b1;
                  lerr_s  = ONE_PIX_ERR;
               end else begin
                  eop_s   = 1'b0;
               end
            end else begin
               acc_s = 1'b0;
            end
         end
         ACTIVE: begin
            if (din_vld) begin
               acc_s = 1'b1;
               if (din_sop) begin
                  // Restart: the aborted frame gets no frame_done.
                  serr_s    = 1'b1;
                  sop_s     = 1'b1;
                  cnt_nxt_s = CNT_ONE;
                  if (din_eop) begin
                     eop_s   = 1'b1;
                     fdone_s = 1'b1;
                     lerr_s  = ONE_PIX_ERR;
                  end else begin
                     eop_s   = 1'b0;
                  end
               end else if (din_eop) begin
                  eop_s     = 1'b1;
                  fdone_s   = 1'b1;
                  lerr_s    = (chk_s != FRAME_CHK);
                  cnt_nxt_s = CNT_ZERO;
               end else if (pix_cnt_r != CNT_MAX) begin
                  cnt_nxt_s = pix_cnt_r + CNT_ONE;
               end else begin
                  cnt_nxt_s = pix_cnt_r;
               end
            end else begin
               acc_s = 1'b0;
            end
         end
         default: begin
            acc_s = 1'b0;
         end
      endcase
   end

   // Stage 1: gray value and filtered framing of the accepted pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_gray_r  <= 8'h00;
         s1_vld_r   <= 1'b0;
         s1_sop_r   <= 1'b0;
         s1_eop_r   <= 1'b0;
         s1_serr_r  <= 1'b0;
         s1_lerr_r  <= 1'b0;
         s1_fdone_r <= 1'b0;
      end else begin
         if (acc_s) begin
            s1_gray_r <= din;
         end else begin
            s1_gray_r <= s1_gray_r;
         end
         s1_vld_r   <= acc_s;
         s1_sop_r   <= sop_s;
         s1_eop_r   <= eop_s;
         s1_serr_r  <= serr_s;
         s1_lerr_r  <= lerr_s;
         s1_fdone_r <= fdone_s;
      end
   end

   // Stage 2: colour mapping; dout holds between valid beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= 16'h0000;
         dout_vld   <= 1'b0;
         dout_sop   <= 1'b0;
         dout_eop   <= 1'b0;
         sop_err    <= 1'b0;
         len_err    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (s1_vld_r) begin
            dout <= map_pix(s1_gray_r);
         end else begin
            dout <= dout;
         end
         dout_vld   <= s1_vld_r;
         dout_sop   <= s1_sop_r;
         dout_eop   <= s1_eop_r;
         sop_err    <= s1_serr_r;
         len_err    <= s1_lerr_r;
         frame_done <= s1_fdone_r;
      end
   end

endmodule

// File: tb/tb_gray_rgb565.sv
// ---------------------------------------------------------------------------
// tb_gray_rgb565 -- directed self-checking bench for gray_rgb565.
// Uses a short frame (FRAME_PIX=32) so a full-length frame fits in a short
// run. Expected colours follow the active build (PSEUDO_COLOR_EN or not).
// ---------------------------------------------------------------------------
module tb_gray_rgb565;

   localparam int FP = 32;
   localparam int CW = 6;

`ifdef PSEUDO_COLOR_EN
   localparam logic [15:0] E_FF = 16'hF800;
   localparam logic [15:0] E_80 = 16'h07E0;
   localparam logic [15:0] E_00 = 16'h001F;
   localparam logic [15:0] E_40 = 16'h07FF;
`else
   localparam logic [15:0] E_FF = 16'hFFFF;
   localparam logic [15:0] E_80 = 16'h8410;
   localparam logic [15:0] E_00 = 16'h0000;
   localparam logic [15:0] E_40 = 16'h4208;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  din;
   logic        din_vld;
   logic        din_sop;
   logic        din_eop;
   logic [15:0] dout;
   logic        dout_vld;
   logic        dout_sop;
   logic        dout_eop;
   logic        sop_err;
   logic        len_err;
   logic        frame_done;

   typedef struct packed {
      logic        vld;
      logic [15:0] d;
      logic        sop;
      logic        eop;
      logic        serr;
      logic        lerr;
      logic        fd;
   } beat_t;

   beat_t q[$];
   int    n_total;
   int    n_bad;

   gray_rgb565 #(.FRAME_PIX(FP), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_vld    (din_vld),
      .din_sop    (din_sop),
      .din_eop    (din_eop),
      .dout       (dout),
      .dout_vld   (dout_vld),
      .dout_sop   (dout_sop),
      .dout_eop   (dout_eop),
      .sop_err    (sop_err),
      .len_err    (len_err),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect every output cycle that carries a valid pixel or any flag.
   always @(negedge clk) begin
      if (!rst && (dout_vld || dout_sop || dout_eop || sop_err || len_err || frame_done)) begin
         q.push_back({dout_vld, dout, dout_sop, dout_eop, sop_err, len_err, frame_done});
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
      din_vld = v;
      din_sop = s;
      din_eop = e;
      din     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Totals over the captured beats: valid, sop, eop, sop_err, len_err, frame_done.
   task automatic tally(output int nv, output int ns, output int ne,
                        output int nse, output int nle, output int nfd);
      nv = 0; ns = 0; ne = 0; nse = 0; nle = 0; nfd = 0;
      foreach (q[i]) begin
         nv  = nv  + int'(q[i].vld);
         ns  = ns  + int'(q[i].sop);
         ne  = ne  + int'(q[i].eop);
         nse = nse + int'(q[i].serr);
         nle = nle + int'(q[i].lerr);
         nfd = nfd + int'(q[i].fd);
      end
   endtask

   function automatic logic [15:0] gray565(input logic [7:0] g);
      return {g[7:3], g[7:2], g[7:3]};
   endfunction

   initial begin
      int nv, ns, ne, nse, nle, nfd;
      int last;
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      din     = 8'h00;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;

      // Reset state
      repeat (3) drive(1'b1, 1'b1, 1'b0, 8'hAA);
      check_eq("rst_dout", 32'(dout), 32'h0000);
      check_eq("rst_flags", {26'd0, dout_vld, dout_sop, dout_eop, sop_err, len_err, frame_done}, 32'd0);
      din_vld = 1'b0;
      din_sop = 1'b0;
      rst     = 1'b0;
      flush();
      q.delete();

      // Scenario 1: 3-pixel frame, latency and length error
      drive(1'b1, 1'b1, 1'b0, 8'hFF);
      check_eq("s1_lat_early", 32'(dout_vld), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h80);
      check_eq("s1_lat_vld", 32'(dout_vld), 32'd1);
      check_eq("s1_lat_dout", 32'(dout), 32'(E_FF));
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      flush();
      check_eq("s1_beats", q.size(), 32'd3);
      check_eq("s1_d0", 32'(q[0].d), 32'(E_FF));
      check_eq("s1_d1", 32'(q[1].d), 32'(E_80));
      check_eq("s1_d2", 32'(q[2].d), 32'(E_00));
      check_eq("s1_sop_eop0", {30'd0, q[0].sop, q[0].eop}, 32'd2);
      check_eq("s1_last_flags", {27'd0, q[2].sop, q[2].eop, q[2].serr, q[2].lerr, q[2].fd}, 32'b01011);
      q.delete();

      // Scenario 2: full-length frame with random gaps
      for (int i = 0; i < FP; i++) begin
         repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 8'h33);
         drive(1'b1, (i == 0), (i == FP - 1), 8'(i * 7));
      end
      flush();
      tally(nv, ns, ne, nse, nle, nfd);
      check_eq("s2_beats", nv, FP);
      check_eq("s2_lerr", nle, 32'd0);
      check_eq("s2_serr", nse, 32'd0);
      check_eq("s2_fd", nfd, 32'd1);
      last = q.size() - 1;
      check_eq("s2_fd_last", {30'd0, q[last].fd, q[last].eop}, 32'd3);
`ifndef PSEUDO_COLOR_EN
      for (int i = 0; i < FP; i++) begin
         check_eq("s2_data", 32'(q[i].d), 32'(gray565(8'(i * 7))));
      end
`endif
      q.delete();

      // Scenario 3: pixels before sop are dropped; framing without vld ignored
      repeat (5) drive(1'b1, 1'b0, 1'b0, 8'h11);
      drive(1'b0, 1'b1, 1'b0, 8'h22);
      drive(1'b0, 1'b0, 1'b1, 8'h22);
      drive(1'b1, 1'b1, 1'b0, 8'h40);
      drive(1'b0, 1'b1, 1'b1, 8'h99);
      drive(1'b1, 1'b0, 1'b0, 8'h80);
      drive(1'b1, 1'b0, 1'b1, 8'hFF);
      flush();
      tally(nv, ns, ne, nse, nle, nfd);
      check_eq("s3_beats", nv, 32'd3);
      check_eq("s3_d0", 32'(q[0].d), 32'(E_40));
      check_eq("s3_sop_first", 32'(q[0].sop), 32'd1);
      check_eq("s3_sop_cnt", ns, 32'd1);
      check_eq("s3_eop_cnt", ne, 32'd1);
      q.delete();

      // Scenario 4: restart after 10 pixels
      for (int i = 0; i < 10; i++) drive(1'b1, (i == 0), 1'b0, 8'h10);
      drive(1'b1, 1'b1, 1'b0, 8'h80);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i == 3), 8'h20);
      flush();
      tally(nv, ns, ne, nse, nle, nfd);
      check_eq("s4_beats", nv, 32'd15);
      check_eq("s4_restart_beat", {29'd0, q[10].serr, q[10].sop, q[10].fd}, 32'b110);
      check_eq("s4_restart_dout", 32'(q[10].d), 32'(E_80));
      check_eq("s4_serr_cnt", nse, 32'd1);
      check_eq("s4_fd_cnt", nfd, 32'd1);
      check_eq("s4_fd_last", {30'd0, q[14].fd, q[14].lerr}, 32'd3);
      q.delete();

      // Scenario 5: reset mid-frame
      for (int i = 0; i < 100; i++) drive(1'b1, (i == 0), 1'b0, 8'h5A);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("s5_rst_out", {15'd0, dout_vld, dout}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      q.delete();
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      for (int i = 0; i < FP; i++) drive(1'b1, (i == 0), (i == FP - 1), 8'hFF);
      flush();
      tally(nv, ns, ne, nse, nle, nfd);
      check_eq("s5_beats", nv, FP);
      check_eq("s5_err_cnt", nse + nle, 32'd0);
      check_eq("s5_fd_cnt", nfd, 32'd1);
      check_eq("s5_first_sop", 32'(q[0].sop), 32'd1);
      q.delete();

      // Scenario 7: sop+eop inside a frame, then one-pixel frame from IDLE
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b1, 8'hFF);
      drive(1'b1, 1'b0, 1'b0, 8'h44);
      drive(1'b1, 1'b1, 1'b1, 8'h80);
      flush();
      tally(nv, ns, ne, nse, nle, nfd);
      check_eq("s7_beats", nv, 32'd4);
      check_eq("s7_abort_flags", {27'd0, q[2].sop, q[2].eop, q[2].serr, q[2].lerr, q[2].fd}, 32'b11111);
      check_eq("s7_idle_flags", {27'd0, q[3].sop, q[3].eop, q[3].serr, q[3].lerr, q[3].fd}, 32'b11011);
      check_eq("s7_idle_dout", 32'(q[3].d), 32'(E_80));
      q.delete();

      // Scenario 6: colour mapping at segment boundaries, then hold
      drive(1'b1, 1'b1, 1'b0, 8'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd64);
      drive(1'b1, 1'b0, 1'b0, 8'd128);
      drive(1'b1, 1'b0, 1'b1, 8'd255);
      flush();
      check_eq("s6_beats", q.size(), 32'd4);
      check_eq("s6_d0", 32'(q[0].d), 32'(E_00));
      check_eq("s6_d64", 32'(q[1].d), 32'(E_40));
      check_eq("s6_d128", 32'(q[2].d), 32'(E_80));
      check_eq("s6_d255", 32'(q[3].d), 32'(E_FF));
      check_eq("s6_hold", {15'd0, dout_vld, dout}, 32'(E_FF));
      q.delete();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
